// File: rtl/fp_round_stage.sv
// Two-stage IEEE-754 rounding/packing stage: RISC-V rounding modes, carry-out, overflow and fflags.
// Optional flush-to-zero of subnormal results when FPU_ROUND_FTZ_EN is defined.
module fp_round_stage #(
   parameter int unsigned EXP_BITS = 8,
   parameter int unsigned MAN_BITS = 23
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sgn,
   input  logic [EXP_BITS+1:0]          in_exp,
   input  logic [MAN_BITS:0]            in_man,
   input  logic                         in_guard,
   input  logic                         in_sticky,
   input  logic [2:0]                   in_rm,
   input  logic                         in_special,
   input  logic [EXP_BITS+MAN_BITS:0]   in_special_val,
   input  logic [4:0]                   in_flags,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_BITS+MAN_BITS:0]   out_result,
   output logic [4:0]                   out_fflags
);

   localparam int unsigned EW = EXP_BITS + 2;
   localparam int unsigned XW = EXP_BITS + 3;
   localparam int unsigned MW = MAN_BITS + 1;
   localparam int unsigned RW = MAN_BITS + 2;
   localparam int unsigned FW = EXP_BITS + MAN_BITS + 1;

   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam logic [4:0] FLG_OF = 5'b00100;
   localparam logic [4:0] FLG_UF = 5'b00010;
   localparam logic [4:0] FLG_NX = 5'b00001;

   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_BITS) - 1);

   logic                r1_valid;
   logic                r1_sgn;
   logic [EW-1:0]       r1_exp;
   logic [MW-1:0]       r1_man;
   logic                r1_inc;
   logic                r1_inexact;
   logic                r1_tiny;
   logic [2:0]          r1_rm;
   logic                r1_special;
   logic [FW-1:0]       r1_special_val;
   logic [4:0]          r1_flags;

   logic                r_out_valid;
   logic [FW-1:0]       r_out_result;
   logic [4:0]          r_out_fflags;

   logic                w_s1_adv;
   logic                w_s2_adv;
   logic                w_inexact;
   logic                w_inc;
   logic                w_tiny;
   logic [RW-1:0]       w_man_r;
   logic                w_carry;
   logic signed [XW-1:0] w_exp_x;
   logic signed [XW-1:0] w_exp_r;
   logic [MAN_BITS-1:0] w_frac;
   logic                w_ovf;
   logic                w_sat_max;
   logic [FW-1:0]       w_result;
   logic [4:0]          w_flags;

   assign w_s2_adv  = ~r_out_valid | out_ready;
   assign w_s1_adv  = ~r1_valid | w_s2_adv;
   assign in_ready  = ~r1_valid | ~r_out_valid | out_ready;

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_fflags = r_out_fflags;

   // Round-increment decision; reserved modes fall back to RNE
   assign w_inexact = in_guard | in_sticky;
   assign w_tiny    = (in_exp == '0) & ~in_man[MAN_BITS];

   always_comb begin
      w_inc = in_guard & (in_sticky | in_man[0]);
      case (in_rm)
         RM_RTZ:  w_inc = 1'b0;
         RM_RDN:  w_inc = w_inexact & in_sgn;
         RM_RUP:  w_inc = w_inexact & ~in_sgn;
         RM_RMM:  w_inc = in_guard;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r1_valid       <= 1'b0;
         r1_sgn         <= 1'b0;
         r1_exp         <= '0;
         r1_man         <= '0;
         r1_inc         <= 1'b0;
         r1_inexact     <= 1'b0;
         r1_tiny        <= 1'b0;
         r1_rm          <= '0;
         r1_special     <= 1'b0;
         r1_special_val <= '0;
         r1_flags       <= '0;
      end else if (w_s1_adv) begin
         r1_valid <= in_valid;
         if (in_valid) begin
            r1_sgn         <= in_sgn;
            r1_exp         <= in_exp;
            r1_man         <= in_man;
            r1_inc         <= w_inc;
            r1_inexact     <= w_inexact;
            r1_tiny        <= w_tiny;
            r1_rm          <= in_rm;
            r1_special     <= in_special;
            r1_special_val <= in_special_val;
            r1_flags       <= in_flags;
         end
      end
   end

   // Mantissa increment with carry-out renormalisation and subnormal-to-normal promotion
   assign w_man_r = RW'(r1_man) + RW'(r1_inc);
   assign w_carry = w_man_r[MAN_BITS+1];
   assign w_exp_x = {r1_exp[EW-1], r1_exp};

   always_comb begin
      w_exp_r = w_exp_x;
      w_frac  = w_man_r[MAN_BITS-1:0];
      if (w_carry) begin
         w_frac  = w_man_r[MAN_BITS:1];
         w_exp_r = w_exp_x + XW'(1);
      end else if ((r1_exp == '0) && w_man_r[MAN_BITS]) begin
         w_exp_r = XW'(1);
      end
   end

   assign w_ovf     = (w_exp_r >= EXP_MAX);
   assign w_sat_max = (r1_rm == RM_RTZ) | ((r1_rm == RM_RDN) & ~r1_sgn) |
                      ((r1_rm == RM_RUP) & r1_sgn);

`ifdef FPU_ROUND_FTZ_EN
   logic w_ftz;
   assign w_ftz = r1_exp[EW-1] | (r1_exp == '0);
`endif

   always_comb begin
      w_flags  = r1_flags | {3'b000, r1_tiny & r1_inexact, r1_inexact};
      w_result = {r1_sgn, w_exp_r[EXP_BITS-1:0], w_frac};
      if (w_ovf) begin
         w_flags  = w_flags | FLG_OF | FLG_NX;
         w_result = w_sat_max ? {r1_sgn, {(EXP_BITS-1){1'b1}}, 1'b0, {MAN_BITS{1'b1}}}
                              : {r1_sgn, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      end
`ifdef FPU_ROUND_FTZ_EN
      if (w_ftz) begin
         w_result = {r1_sgn, {(FW-1){1'b0}}};
         w_flags  = r1_flags | FLG_UF | FLG_NX;
      end
`endif
      if (r1_special) begin
         w_result = r1_special_val;
         w_flags  = r1_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_fflags <= '0;
      end else if (w_s2_adv) begin
         r_out_valid <= r1_valid;
         if (r1_valid) begin
            r_out_result <= w_result;
            r_out_fflags <= w_flags;
         end
      end
   end

`ifndef FPU_ROUND_FTZ_EN
   // Negative exponents are only legal when flush-to-zero is built in
   a_exp_nonneg: assert property (@(posedge clk) disable iff (!reset_n)
      (in_valid && in_ready && !in_special) |-> !in_exp[EXP_BITS+1]);
`endif

endmodule

// File: tb/tb_fp_round_stage.sv
// Scoreboard bench for fp_round_stage: vector table, latency, backpressure and reset corner cases.
module tb_fp_round_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sgn;
   logic [9:0]  in_exp;
   logic [23:0] in_man;
   logic        in_guard;
   logic        in_sticky;
   logic [2:0]  in_rm;
   logic        in_special;
   logic [31:0] in_special_val;
   logic [4:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_fflags;

   typedef struct {
      logic        sgn;
      logic [9:0]  exp;
      logic [23:0] man;
      logic        g;
      logic        s;
      logic [2:0]  rm;
      logic        spec;
      logic [31:0] sval;
      logic [4:0]  flg;
      logic [31:0] e_res;
      logic [4:0]  e_flg;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks;
   int   errors;

   fp_round_stage #(.EXP_BITS(8), .MAN_BITS(23)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sgn(in_sgn), .in_exp(in_exp), .in_man(in_man), .in_guard(in_guard),
      .in_sticky(in_sticky), .in_rm(in_rm), .in_special(in_special),
      .in_special_val(in_special_val), .in_flags(in_flags), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_fflags(out_fflags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, want);
      end
   endtask

   task automatic add(input logic sgn, input logic [9:0] exp, input logic [23:0] man,
                      input logic g, input logic s, input logic [2:0] rm, input logic [4:0] flg,
                      input logic [31:0] e_res, input logic [4:0] e_flg);
      vec_t v;
      v.sgn = sgn; v.exp = exp; v.man = man; v.g = g; v.s = s; v.rm = rm;
      v.spec = 1'b0; v.sval = '0; v.flg = flg; v.e_res = e_res; v.e_flg = e_flg;
      vecs.push_back(v);
   endtask

   task automatic add_spec(input logic [31:0] sval, input logic [4:0] flg);
      vec_t v;
      v.sgn = 1'b0; v.exp = '0; v.man = '0; v.g = 1'b1; v.s = 1'b1; v.rm = 3'b011;
      v.spec = 1'b1; v.sval = sval; v.flg = flg; v.e_res = sval; v.e_flg = flg;
      vecs.push_back(v);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input vec_t v);
      exp_t e;
      bit   ok;
      in_sgn = v.sgn; in_exp = v.exp; in_man = v.man; in_guard = v.g; in_sticky = v.s;
      in_rm = v.rm; in_special = v.spec; in_special_val = v.sval; in_flags = v.flg;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (ok) begin
         e.res = v.e_res;
         e.flg = v.e_flg;
         sb_q.push_back(e);
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout beat not accepted, expected acceptance");
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (reset_n && out_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output got %h/%h expected no output", out_result, out_fflags);
            end else begin
               chk("result", out_result, sb_q[0].res);
               chk("fflags", 32'(out_fflags), 32'(sb_q[0].flg));
               if (out_ready) void'(sb_q.pop_front());
            end
         end
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_sgn = 1'b0; in_exp = '0; in_man = '0; in_guard = 1'b0; in_sticky = 1'b0;
      in_rm = '0; in_special = 1'b0; in_special_val = '0; in_flags = '0;

      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog simulation did not complete");
            $fatal(1);
         end
      join_none

      // Vector table
      add(0, 10'd127, 24'h800001, 1, 0, 3'b000, 5'h00, 32'h3F800002, 5'h01);
      add(0, 10'd127, 24'hFFFFFF, 1, 1, 3'b000, 5'h00, 32'h40000000, 5'h01);
      add(0, 10'd254, 24'hFFFFFF, 1, 0, 3'b000, 5'h00, 32'h7F800000, 5'h05);
      add(0, 10'd255, 24'h800000, 0, 0, 3'b001, 5'h00, 32'h7F7FFFFF, 5'h05);
      add(1, 10'd255, 24'h800000, 0, 0, 3'b010, 5'h00, 32'hFF800000, 5'h05);
`ifdef FPU_ROUND_FTZ_EN
      add(0, 10'd0,   24'h7FFFFF, 1, 0, 3'b000, 5'h00, 32'h00000000, 5'h03);
      add(0, 10'd0,   24'h000010, 0, 1, 3'b011, 5'h00, 32'h00000000, 5'h03);
      add(0, 10'd0,   24'h000010, 0, 0, 3'b000, 5'h00, 32'h00000000, 5'h03);
`else
      add(0, 10'd0,   24'h7FFFFF, 1, 0, 3'b000, 5'h00, 32'h00800000, 5'h03);
      add(0, 10'd0,   24'h000010, 0, 1, 3'b011, 5'h00, 32'h00000011, 5'h03);
      add(0, 10'd0,   24'h000010, 0, 0, 3'b000, 5'h00, 32'h00000010, 5'h00);
`endif
      add_spec(32'h7FC00000, 5'h10);
      add(0, 10'd127, 24'h800000, 1, 0, 3'b000, 5'h00, 32'h3F800000, 5'h01);
      add(1, 10'd127, 24'h800003, 1, 1, 3'b001, 5'h00, 32'hBF800003, 5'h01);
      add(1, 10'd128, 24'h800000, 0, 1, 3'b010, 5'h00, 32'hC0000001, 5'h01);
      add(0, 10'd128, 24'hC00000, 0, 1, 3'b011, 5'h00, 32'h40400001, 5'h01);
      add(1, 10'd128, 24'hC00000, 0, 1, 3'b011, 5'h00, 32'hC0400000, 5'h01);
      add(0, 10'd127, 24'h800000, 1, 0, 3'b100, 5'h00, 32'h3F800001, 5'h01);
      add(0, 10'd127, 24'hA00000, 0, 0, 3'b000, 5'h00, 32'h3FA00000, 5'h00);
      add(0, 10'd127, 24'h800001, 1, 0, 3'b111, 5'h00, 32'h3F800002, 5'h01);
      add(0, 10'd127, 24'h800000, 0, 0, 3'b000, 5'h08, 32'h3F800000, 5'h08);
      add(1, 10'd255, 24'h800000, 0, 0, 3'b011, 5'h00, 32'hFF7FFFFF, 5'h05);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_fflags", 32'(out_fflags), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Latency: out_valid exactly two cycles after accept
      send(vecs[0]);
      @(negedge clk);
      chk("lat_1cyc_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_2cyc_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      drain();

      // Table, back-to-back
      foreach (vecs[i]) send(vecs[i]);
      drain();

      // Backpressure: four beats, out_ready low over cycles 2..5
      @(posedge clk); #1;
      fork
         for (int i = 0; i < 4; i++) send(vecs[i+1]);
         begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready_full", 32'(in_ready), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages occupied
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(vecs[1]);
      send(vecs[2]);
      reset_n = 1'b0;
      sb_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_result", out_result, 32'd0);
      chk("midrst_out_fflags", 32'(out_fflags), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (5) @(posedge clk);
      #1;

      // Special bypass after reset
      send(vecs[8]);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
